// File: rtl/dac_sched.sv
`default_nettype none
// ============================================================================
// Module   : dac_sched
// Purpose  : Update scheduler / arbiter for the serial OCXO-trim DAC driver.
//            Captures target codes from the PLL loop filter and from a CPU
//            manual override, clamps and slew-limits the chosen code, and
//            changes dac_val only once the driver's per-second shift frame is
//            over, so a code never changes mid-shift.
// Ports    : clk, rst (sync, active-high)
//            tsc_1pps/tsc_1ppms  - second marker and millisecond tick strobe
//            cfg_ena/cfg_manual/cfg_tri/cfg_min/cfg_max - configuration
//            pll_req/pll_val/pll_ack - PLL target request and completion ack
//            cpu_req/cpu_val/cpu_ack - CPU target request and completion ack
//            dac_ena/dac_tri/dac_val - to the serial DAC driver
//            busy/slew_act/clamp_hit/drop_cnt - status
// Revision : 1.0 - initial release
// ============================================================================
module dac_sched #(
  parameter logic [15:0] MAX_STEP = 16'd256,
  parameter int          SHIFT_MS = 33,
  parameter logic [15:0] INIT_VAL = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tsc_1pps,
  input  logic        tsc_1ppms,
  input  logic        cfg_ena,
  input  logic        cfg_manual,
  input  logic        cfg_tri,
  input  logic [15:0] cfg_min,
  input  logic [15:0] cfg_max,
  input  logic        pll_req,
  input  logic [15:0] pll_val,
  output logic        pll_ack,
  input  logic        cpu_req,
  input  logic [15:0] cpu_val,
  output logic        cpu_ack,
  output logic        dac_ena,
  output logic        dac_tri,
  output logic [15:0] dac_val,
  output logic        busy,
  output logic        slew_act,
  output logic        clamp_hit,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_UPDATE   = 2'd3
  } state_t;

  localparam logic [15:0] C_SHIFT_MS = 16'(SHIFT_MS);

  state_t      state_q, state_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pend_src_q, pend_src_d;   // 1 = CPU, 0 = PLL
  logic [15:0] pend_val_q, pend_val_d;
  logic [15:0] dac_val_q, dac_val_d;
  logic        dac_ena_q, dac_ena_d;
  logic        dac_tri_q, dac_tri_d;
  logic        busy_q, busy_d;
  logic        slew_q, slew_d;
  logic        clamp_q, clamp_d;
  logic        pll_ack_q, pll_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [7:0]  drop_q, drop_d;

  logic        strobe;
  logic [15:0] ms_inc;
  logic [15:0] upper_lim;
  logic [15:0] tgt;
  logic [16:0] diff;
  logic [16:0] mag;

  assign strobe = tsc_1pps & tsc_1ppms;
  assign ms_inc = ms_cnt_q + 16'd1;

  // Clamp: apply the upper limit first, then the lower one, so cfg_min wins
  // when the two limits are crossed.
  assign upper_lim = (pend_val_q > cfg_max) ? cfg_max : pend_val_q;
  assign tgt       = (upper_lim < cfg_min) ? cfg_min : upper_lim;

  // Both operands are 16-bit unsigned, so bit 16 of the 17-bit difference is
  // the sign of (tgt - dac_val).
  assign diff = {1'b0, tgt} - {1'b0, dac_val_q};
  assign mag  = diff[16] ? (17'd0 - diff) : diff;

  always_comb begin
    state_d    = state_q;
    ms_cnt_d   = ms_cnt_q;
    pend_vld_d = pend_vld_q;
    pend_src_d = pend_src_q;
    pend_val_d = pend_val_q;
    dac_val_d  = dac_val_q;
    slew_d     = slew_q;
    clamp_d    = clamp_q;
    drop_d     = drop_q;
    pll_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    dac_ena_d  = (state_q != ST_DISABLED);
    dac_tri_d  = cfg_tri;

    case (state_q)
      ST_DISABLED: begin
        pend_vld_d = 1'b0;
        if (cfg_ena) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (strobe) begin
          state_d  = ST_SHIFT;
          ms_cnt_d = 16'd0;
        end
      end
      ST_SHIFT: begin
        if (strobe) begin
          ms_cnt_d = 16'd0;
        end else if (tsc_1ppms) begin
          ms_cnt_d = ms_inc;
          if (ms_inc == C_SHIFT_MS) state_d = pend_vld_q ? ST_UPDATE : ST_IDLE;
        end
      end
      default: begin // ST_UPDATE
        state_d = ST_IDLE;
        clamp_d = (tgt != pend_val_q);
        if (mag > {1'b0, MAX_STEP}) begin
          // Step-limited: pend_vld stays set so the next second continues.
          dac_val_d = diff[16] ? (dac_val_q - MAX_STEP) : (dac_val_q + MAX_STEP);
          slew_d    = 1'b1;
        end else begin
          dac_val_d  = tgt;
          slew_d     = 1'b0;
          pend_vld_d = 1'b0;
          cpu_ack_d  = pend_src_q;
          pll_ack_d  = ~pend_src_q;
        end
      end
    endcase

    // Request capture comes after the FSM so a capture in the UPDATE cycle
    // survives as the pending request for the next second.
    if (state_q != ST_DISABLED) begin
      if (cpu_req) begin
        pend_vld_d = 1'b1;
        pend_src_d = 1'b1;
        pend_val_d = cpu_val;
      end else if (pll_req && !cfg_manual) begin
        pend_vld_d = 1'b1;
        pend_src_d = 1'b0;
        pend_val_d = pll_val;
      end
      if (pll_req && (cpu_req || cfg_manual) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    if (!cfg_ena) begin
      state_d    = ST_DISABLED;
      pend_vld_d = 1'b0;
    end

    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DISABLED;
      ms_cnt_q   <= 16'd0;
      pend_vld_q <= 1'b0;
      pend_src_q <= 1'b0;
      pend_val_q <= 16'd0;
      dac_val_q  <= INIT_VAL;
      dac_ena_q  <= 1'b0;
      dac_tri_q  <= 1'b1;
      busy_q     <= 1'b0;
      slew_q     <= 1'b0;
      clamp_q    <= 1'b0;
      pll_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      ms_cnt_q   <= ms_cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_src_q <= pend_src_d;
      pend_val_q <= pend_val_d;
      dac_val_q  <= dac_val_d;
      dac_ena_q  <= dac_ena_d;
      dac_tri_q  <= dac_tri_d;
      busy_q     <= busy_d;
      slew_q     <= slew_d;
      clamp_q    <= clamp_d;
      pll_ack_q  <= pll_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      drop_q     <= drop_d;
    end
  end

  assign pll_ack   = pll_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign dac_ena   = dac_ena_q;
  assign dac_tri   = dac_tri_q;
  assign dac_val   = dac_val_q;
  assign busy      = busy_q;
  assign slew_act  = slew_q;
  assign clamp_hit = clamp_q;
  assign drop_cnt  = drop_q;

endmodule
`default_nettype wire
